gen_share_arbiter: RTL

//   Shares one generator instance (hrange-style: start/args in, ready/valid tuple out, done) between two

---
 rtl/gen_share_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gen_share_arbiter.sv
// rtl/gen_share_arbiter.sv - round-robin share of one range generator between two requesters
module gen_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    r0_start,
    input  logic signed [WIDTH-1:0] r0_base,
    input  logic signed [WIDTH-1:0] r0_limit,
    input  logic signed [WIDTH-1:0] r0_step,
    input  logic                    r0_abort,
    input  logic                    r0_ready,
    output logic                    r0_valid,
    output logic signed [WIDTH-1:0] r0_0,
    output logic signed [WIDTH-1:0] r0_1,
    output logic                    r0_done,
    output logic                    r0_busy,
    input  logic                    r1_start,
    input  logic signed [WIDTH-1:0] r1_base,
    input  logic signed [WIDTH-1:0] r1_limit,
    input  logic signed [WIDTH-1:0] r1_step,
    input  logic                    r1_abort,
    input  logic                    r1_ready,
    output logic                    r1_valid,
    output logic signed [WIDTH-1:0] r1_0,
    output logic signed [WIDTH-1:0] r1_1,
    output logic                    r1_done,
    output logic                    r1_busy,
    output logic                    g_start,
    output logic signed [WIDTH-1:0] g_base,
    output logic signed [WIDTH-1:0] g_limit,
    output logic signed [WIDTH-1:0] g_step,
    output logic                    g_reset,
    output logic                    g_ready,
    input  logic                    g_valid,
    input  logic                    g_done,
    input  logic signed [WIDTH-1:0] g_0,
    input  logic signed [WIDTH-1:0] g_1
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_STREAM, S_DRAIN} state_t;

    state_t state, state_next;
    logic [1:0] pending, pending_next, abort_done;
    logic       grant, grant_next, last_grant;
    logic [1:0] busy, start_acc, abort_in, ready_in, active_mask, pend_abort, req;
    logic       g_abort, fwd_valid;

    logic signed [WIDTH-1:0] base_in [2];
    logic signed [WIDTH-1:0] limit_in [2];
    logic signed [WIDTH-1:0] step_in [2];
    logic signed [WIDTH-1:0] base_q [2];
    logic signed [WIDTH-1:0] limit_q [2];
    logic signed [WIDTH-1:0] step_q [2];

    assign base_in[0]  = r0_base;
    assign base_in[1]  = r1_base;
    assign limit_in[0] = r0_limit;
    assign limit_in[1] = r1_limit;
    assign step_in[0]  = r0_step;
    assign step_in[1]  = r1_step;

    // A requester stays busy through its done pulse so a start in that cycle is dropped
    assign busy        = pending | abort_done;
    assign start_acc   = {r1_start, r0_start} & ~busy;
    assign abort_in    = {r1_abort, r0_abort};
    assign ready_in    = {r1_ready, r0_ready};
    assign active_mask = (state == S_IDLE) ? 2'b00 : (grant ? 2'b10 : 2'b01);
    assign pend_abort  = pending & abort_in & ~active_mask;
    assign req         = pending & ~pend_abort;
    assign g_abort     = ((state == S_LAUNCH) || (state == S_STREAM)) && abort_in[grant];

    // Next-state, grant selection and generator handshake
    always_comb begin
        state_next   = state;
        grant_next   = grant;
        g_start      = 1'b0;
        g_ready      = 1'b0;
        fwd_valid    = 1'b0;
        pending_next = (pending | start_acc) & ~pend_abort;
        case (state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    grant_next = (req == 2'b11) ? ~last_grant : req[1];
                    g_start    = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = g_abort ? S_DRAIN : S_STREAM;
            end
            S_STREAM: begin
                g_ready   = ready_in[grant] & ~g_abort;
                fwd_valid = g_valid & ~g_abort;
                if (g_abort || g_done) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                pending_next[grant] = 1'b0;
                state_next          = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, grant history and pending-request bookkeeping
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state      <= S_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            pending    <= 2'b00;
            abort_done <= 2'b00;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            pending    <= pending_next;
            abort_done <= pend_abort;
            if (state == S_DRAIN) begin
                last_grant <= grant;
            end
        end
    end

    // Argument capture on an accepted start
    always_ff @(posedge _clock) begin
        if (_reset) begin
            for (int n = 0; n < 2; n++) begin
                base_q[n]  <= '0;
                limit_q[n] <= '0;
                step_q[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (start_acc[n]) begin
                    base_q[n]  <= base_in[n];
                    limit_q[n] <= limit_in[n];
                    step_q[n]  <= step_in[n];
                end
            end
        end
    end

    assign g_base  = base_q[grant_next];
    assign g_limit = limit_q[grant_next];
    assign g_step  = step_q[grant_next];
    assign g_reset = _reset | g_abort;

    assign r0_valid = fwd_valid & ~grant;
    assign r1_valid = fwd_valid & grant;
    assign r0_0     = ((state == S_STREAM) && !grant) ? g_0 : '0;
    assign r0_1     = ((state == S_STREAM) && !grant) ? g_1 : '0;
    assign r1_0     = ((state == S_STREAM) && grant) ? g_0 : '0;
    assign r1_1     = ((state == S_STREAM) && grant) ? g_1 : '0;
    assign r0_done  = ((state == S_DRAIN) && !grant) | abort_done[0];
    assign r1_done  = ((state == S_DRAIN) && grant) | abort_done[1];
    assign r0_busy  = busy[0];
    assign r1_busy  = busy[1];
endmodule
